// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding,
// requester-select codes and the width of the internal counters.
package mem_arbiter_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CPU  = 2'd1,
        SEL_DMA  = 2'd2
    } sel_t;

    // wait_cnt and beat_cnt are 4 bits wide (MAX_WAIT, BURST_LEN <= 15)
    localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side access port of the memory arbiter.
//   req/we/addr/wdata : request, held stable until gnt
//   gnt               : access performed this cycle
//   rvalid/rdata      : read response, one cycle after a granted read
// master = requester (CPU or DMA), slave = arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_arbiter_read_return.sv
// Per-port read return path.
//   clock, reset : clock, asynchronous active-low reset
//   read_gnt     : a read was granted to this port this cycle
//   mem_rdata    : memory read data (valid one clock after the address)
//   rvalid       : high exactly one cycle after a granted read
//   rdata        : live memory data while rvalid, held value otherwise
module mem_arbiter_read_return #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read_gnt,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] hold;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rvalid <= 1'b0;
            hold   <= '0;
        end else begin
            rvalid <= read_gnt;
            if (rvalid) begin
                hold <= mem_rdata;
            end
        end
    end

    assign rdata = rvalid ? mem_rdata : hold;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single memory_block port between the CPU and a
// DMA-style requester. CPU has default priority; the DMA side wins after
// MAX_WAIT consecutive denied cycles and then keeps the port for up to
// BURST_LEN consecutive beats.
//   clock, reset : clock, asynchronous active-low reset
//   cpu, dma     : requester ports (mem_arbiter_if slave modport)
//   mem_addr/we/wdata : memory request, driven by the winner, 0 when idle
//   mem_rdata    : memory read data, valid one clock after the address
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_arbiter_if.slave          cpu,
    mem_arbiter_if.slave          dma,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [CNT_WIDTH-1:0] MAX_WAIT_C  = CNT_WIDTH'(MAX_WAIT);
    localparam logic [CNT_WIDTH-1:0] BURST_LEN_C = CNT_WIDTH'(BURST_LEN);

    state_t               state, state_next;
    sel_t                 sel;
    logic [CNT_WIDTH-1:0] wait_cnt, wait_next;
    logic [CNT_WIDTH-1:0] beat_cnt, beat_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_CPU;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            beat_cnt <= beat_next;
        end
    end

    // A burst that cannot continue falls straight through to the S_CPU
    // rules in the same cycle, so there is never an idle bubble.
    always_comb begin
        state_next = state;
        beat_next  = beat_cnt;
        sel        = SEL_NONE;
        if (state == S_DMA && dma.req && beat_cnt < BURST_LEN_C) begin
            sel       = SEL_DMA;
            beat_next = beat_cnt + 1'b1;
        end else begin
            state_next = S_CPU;
            if (cpu.req && wait_cnt < MAX_WAIT_C) begin
                sel = SEL_CPU;
            end else if (dma.req) begin
                sel        = SEL_DMA;
                beat_next  = CNT_WIDTH'(1);
                state_next = (BURST_LEN_C == CNT_WIDTH'(1)) ? S_CPU : S_DMA;
            end
        end
        // grants are combinational; keep them low while reset is held
        if (!reset) begin
            sel = SEL_NONE;
        end
    end

    always_comb begin
        wait_next = wait_cnt;
        if (sel == SEL_DMA) begin
            wait_next = '0;
        end else if (dma.req && wait_cnt < MAX_WAIT_C) begin
            wait_next = wait_cnt + 1'b1;
        end
    end

    assign cpu.gnt = (sel == SEL_CPU);
    assign dma.gnt = (sel == SEL_DMA);

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (sel)
            SEL_CPU: begin
                mem_addr  = cpu.addr;
                mem_we    = cpu.we;
                mem_wdata = cpu.wdata;
            end
            SEL_DMA: begin
                mem_addr  = dma.addr;
                mem_we    = dma.we;
                mem_wdata = dma.wdata;
            end
            default: ;
        endcase
    end

    mem_arbiter_read_return #(.DATA_WIDTH(DATA_WIDTH)) u_cpu_ret (
        .clock     (clock),
        .reset     (reset),
        .read_gnt  (cpu.gnt && !cpu.we),
        .mem_rdata (mem_rdata),
        .rvalid    (cpu.rvalid),
        .rdata     (cpu.rdata)
    );

    mem_arbiter_read_return #(.DATA_WIDTH(DATA_WIDTH)) u_dma_ret (
        .clock     (clock),
        .reset     (reset),
        .read_gnt  (dma.gnt && !dma.we),
        .mem_rdata (mem_rdata),
        .rvalid    (dma.rvalid),
        .rdata     (dma.rdata)
    );

endmodule
